// File: rtl/shift_cmd_sequencer.sv
// shift_cmd_sequencer: buffers {opcode, load data, repeat} commands in a small
// circular FIFO and issues them one at a time to a 4-bit opcode shift register.
// Each opcode is held for rep+1 cycles; load (111) always issues once.
// With nothing to do, the hold opcode (000) is driven.
// Optional macro SHIFT_CMD_SEQ_FLUSH_EN adds a synchronous flush input.
module shift_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int REP_W = 4
) (
  input  logic                   clk,
  input  logic                   R_n,
`ifdef SHIFT_CMD_SEQ_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [3:0]             cmd_data,
  input  logic [REP_W-1:0]       cmd_rep,
  output logic [2:0]             S,
  output logic [3:0]             L,
  output logic                   busy,
  output logic                   last,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b111;

  typedef struct packed {
    logic [2:0]       op;
    logic [3:0]       data;
    logic [REP_W-1:0] rep;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  cmd_t             mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [3:0]       l_q, l_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             busy_q, busy_d;

  logic flush_w, push, pop, last_w;
  cmd_t head, cmd_in;

`ifdef SHIFT_CMD_SEQ_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Ready comes only from the registered count, so a same-edge pop never
  // feeds back into ready.
  assign cmd_ready  = (count_q != FULL_CNT);
  assign cmd_in     = '{op: cmd_op, data: cmd_data, rep: cmd_rep};
  assign head       = mem_q[rd_ptr_q];
  assign last_w     = (state_q == ISSUE) && (rep_q == '0);
  assign push       = cmd_valid && cmd_ready && !flush_w;
  // Pop whenever the issue slot frees up: idle, or final cycle of a command.
  assign pop        = !flush_w && (count_q != '0) && ((state_q == IDLE) || last_w);

  assign S          = s_q;
  assign L          = l_q;
  assign busy       = busy_q;
  assign last       = last_w;
  assign fifo_count = count_q;

  // FIFO storage; entries are only read after being written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd_in;
  end

  // Next-state for FIFO pointers/count and the issue FSM with its outputs.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    s_d      = s_q;
    l_d      = l_q;
    rep_d    = rep_q;
    busy_d   = busy_q;
    if (flush_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = IDLE;
      s_d      = OP_HOLD;
      l_d      = 4'b0000;
      rep_d    = '0;
      busy_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;

      if (pop) begin
        // Load issues exactly once and is the only opcode carrying data.
        state_d = ISSUE;
        busy_d  = 1'b1;
        s_d     = head.op;
        l_d     = (head.op == OP_LOAD) ? head.data : 4'b0000;
        rep_d   = (head.op == OP_LOAD) ? '0 : head.rep;
      end else if (state_q == ISSUE) begin
        if (last_w) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          s_d     = OP_HOLD;
          l_d     = 4'b0000;
        end else begin
          rep_d   = rep_q - 1'b1;
        end
      end
    end
  end

  // State registers; asynchronous reset empties FIFO and returns to idle.
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      s_q      <= OP_HOLD;
      l_q      <= 4'b0000;
      rep_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      s_q      <= s_d;
      l_q      <= l_d;
      rep_q    <= rep_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_shift_cmd_sequencer.sv
// Bench for shift_cmd_sequencer: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_shift_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int REP_W = 4;

  logic clk, R_n, cmd_valid, cmd_ready, busy, last;
  logic [2:0] cmd_op, S;
  logic [3:0] cmd_data, L;
  logic [REP_W-1:0] cmd_rep;
  logic [$clog2(DEPTH):0] fifo_count;
  logic flush_r;

  shift_cmd_sequencer #(.DEPTH(DEPTH), .REP_W(REP_W)) dut (
    .clk(clk), .R_n(R_n),
`ifdef SHIFT_CMD_SEQ_FLUSH_EN
    .flush(flush_r),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_rep(cmd_rep), .S(S), .L(L), .busy(busy),
    .last(last), .fifo_count(fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // {S, L, busy, last, fifo_count, cmd_ready}
  function automatic logic [12:0] pk(logic [2:0] s, logic [3:0] l, logic b,
                                     logic la, logic [2:0] c, logic r);
    return {s, l, b, la, c, r};
  endfunction

  function automatic logic [12:0] dut_pk();
    return {S, L, busy, last, fifo_count, cmd_ready};
  endfunction

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got S/L/busy/last/cnt/rdy=%b expected %b", name, act, exp);
    end
  endtask

  // Reference model: queue of pending commands plus the active command and
  // the number of issue cycles it still has (including the current one).
  typedef struct {
    logic [2:0] op;
    logic [3:0] d;
    int         rep;
  } mcmd_t;

  mcmd_t mq[$];
  mcmd_t m_cur;
  bit    m_act;
  int    m_rem;
  bit    dut_acc;

  function automatic logic [12:0] m_exp();
    logic [2:0] s;
    logic [3:0] l;
    s = m_act ? m_cur.op : 3'd0;
    l = (m_act && m_cur.op == 3'd7) ? m_cur.d : 4'd0;
    return pk(s, l, m_act, m_act && (m_rem == 1), 3'(mq.size()), mq.size() < DEPTH);
  endfunction

  task automatic model_edge(input bit v, input mcmd_t c);
    bit acc;
    acc = v && (mq.size() < DEPTH) && !flush_r;
    if (flush_r) begin
      mq.delete();
      m_act = 1'b0;
    end else begin
      if (m_act && m_rem > 1) m_rem--;
      else if (mq.size() > 0) begin
        m_cur = mq.pop_front();
        m_act = 1'b1;
        m_rem = (m_cur.op == 3'd7) ? 1 : m_cur.rep + 1;
      end else m_act = 1'b0;
      if (acc) mq.push_back(c);
    end
  endtask

  // One clock: drive at negedge, model update at posedge, compare 1ns later.
  task automatic step(input bit v, input logic [2:0] op, input logic [3:0] d,
                      input logic [REP_W-1:0] rep);
    mcmd_t c;
    c.op = op; c.d = d; c.rep = int'(rep);
    @(negedge clk);
    cmd_valid = v; cmd_op = op; cmd_data = d; cmd_rep = rep;
    dut_acc = v && cmd_ready;
    @(posedge clk);
    model_edge(v, c);
    #1;
    chk("model", dut_pk(), m_exp());
  endtask

  task automatic do_reset();
    @(negedge clk);
    R_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_rep = '0;
    flush_r = 1'b0;
    mq.delete();
    m_act = 1'b0;
    m_rem = 0;
    @(negedge clk);
    chk("reset_state", dut_pk(), pk(3'd0, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1));
    @(negedge clk);
    R_n = 1'b1;
  endtask

  typedef struct {
    logic       v;
    logic [2:0] op;
    logic [3:0] d;
    logic [3:0] rep;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] fops[5];
    logic [2:0] got[$];
    int i, pop_e, acc5_e;
    bit seen3, chk4done;

    // single command, back-to-back load, multi-cycle hold opcode
    tbl[0]  = '{1'b1, 3'd1, 4'h0, 4'd2, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1)};
    tbl[1]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd1, 4'h0, 1'b1, 1'b0, 3'd0, 1'b1)};
    tbl[2]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd1, 4'h0, 1'b1, 1'b0, 3'd0, 1'b1)};
    tbl[3]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd1, 4'h0, 1'b1, 1'b1, 3'd0, 1'b1)};
    tbl[4]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1)};
    tbl[5]  = '{1'b1, 3'd7, 4'hA, 4'd5, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1)};
    tbl[6]  = '{1'b1, 3'd6, 4'hF, 4'd0, pk(3'd7, 4'hA, 1'b1, 1'b1, 3'd1, 1'b1)};
    tbl[7]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd6, 4'h0, 1'b1, 1'b1, 3'd0, 1'b1)};
    tbl[8]  = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1)};
    tbl[9]  = '{1'b1, 3'd0, 4'h5, 4'd1, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd1, 1'b1)};
    tbl[10] = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd0, 4'h0, 1'b1, 1'b0, 3'd0, 1'b1)};
    tbl[11] = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd0, 4'h0, 1'b1, 1'b1, 3'd0, 1'b1)};
    tbl[12] = '{1'b0, 3'd0, 4'h0, 4'd0, pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1)};
    fops = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6};

    R_n = 1'b0; flush_r = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_rep = '0;
    do_reset();

    // directed vector table
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].v, tbl[k].op, tbl[k].d, tbl[k].rep);
      chk($sformatf("vec%0d", k), dut_pk(), tbl[k].exp);
    end

    // asynchronous reset in the middle of a long command
    do_reset();
    step(1'b1, 3'd1, 4'h0, 4'd7);
    for (int k = 0; k < 3; k++) step(1'b0, 3'd0, 4'h0, 4'd0);
    #1 R_n = 1'b0;
    #1 chk("async_reset_mid_cmd", dut_pk(), pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1));
    do_reset();

    // full FIFO behind a 16-cycle command; fifth entry waits for first pop
    step(1'b1, 3'd3, 4'h0, 4'd15);
    i = 0; pop_e = -1; acc5_e = -1; seen3 = 1'b0; chk4done = 1'b0;
    for (int k = 0; k < 40 && i < 5; k++) begin
      step(1'b1, fops[i], 4'h0, 4'd0);
      if (dut_acc) begin
        i++;
        if (i == 5) acc5_e = k;
      end
      if (i == 4 && !chk4done) begin
        chk4done = 1'b1;
        tests++;
        if (fifo_count !== 3'd4 || cmd_ready !== 1'b0) begin
          fails++;
          $display("FAIL full_flag: got cnt=%0d rdy=%b expected cnt=4 rdy=0", fifo_count, cmd_ready);
        end
      end
      if (S == 3'd3) seen3 = 1'b1;
      else if (seen3 && pop_e < 0) pop_e = k;
    end
    tests++;
    if (!chk4done || acc5_e < 0 || pop_e < 0 || acc5_e != pop_e + 1) begin
      fails++;
      $display("FAIL fifth_accept: got accept step %0d pop step %0d expected accept one after pop", acc5_e, pop_e);
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 8; k++) step(1'b0, 3'd0, 4'h0, 4'd0);

    // wrap-around: 10 single-cycle commands streamed back to back
    do_reset();
    i = 0;
    got.delete();
    for (int k = 0; k < 40 && (i < 10 || busy); k++) begin
      step(i < 10, 3'(1 + i % 6), 4'h0, 4'd0);
      if (dut_acc) i++;
      if (busy) got.push_back(S);
    end
    begin
      int bad;
      bad = (got.size() != 10) ? 0 : -1;
      for (int k = 0; k < got.size() && k < 10 && bad < 0; k++)
        if (got[k] !== 3'(1 + k % 6)) bad = k;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL wrap_order: got %0d issues (first bad idx %0d) expected 10 in order 1..6", got.size(), bad);
      end
    end

`ifdef SHIFT_CMD_SEQ_FLUSH_EN
    // flush while busy with three queued and a same-edge push
    do_reset();
    step(1'b1, 3'd1, 4'h0, 4'd7);
    step(1'b1, 3'd2, 4'h0, 4'd0);
    step(1'b1, 3'd3, 4'h0, 4'd0);
    step(1'b1, 3'd4, 4'h0, 4'd0);
    flush_r = 1'b1;
    step(1'b1, 3'd5, 4'h0, 4'd0);
    flush_r = 1'b0;
    chk("flush", dut_pk(), pk(3'd0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1));
    for (int k = 0; k < 4; k++) step(1'b0, 3'd0, 4'h0, 4'd0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      logic [REP_W-1:0] r;
      r = ($urandom_range(0, 9) == 0) ? REP_W'($urandom_range(0, 15)) : REP_W'($urandom_range(0, 2));
      step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
